uart_byte_receiver: RTL and testbench
=====================================

# uart_byte_receiver

Serial-to-byte front end of the message path. It samples the asynchronous UART line from the host, recovers 8N1 frames, and presents each good byte on `rx_data` with a single-cycle `rx_data_ready` strobe. Those two outputs connect directly to `serial_msg_receiver` (`rx_data`, `rx_data_ready`). Framing errors are flagged and never forwarded as data.

## Interface
- `CLKS_PER_BIT`, 104: clock cycles per bit (12 MHz / 115200). Minimum 8.
- `clk` input 1: system clock; all logic on its rising edge.
- `reset` input 1: synchronous, active-high.
- `rx_serial` input 1: asynchronous UART line; idle high.
- `rx_data` output 8: last correctly framed byte; LSB received first.
- `rx_data_ready` output 1: one-cycle pulse; `rx_data` is valid and updated in the same cycle.
- `rx_frame_error` output 1: one-cycle pulse on a bad stop bit.
- `rx_busy` output 1: high from start-bit detection until the frame ends or is rejected.

## Operation
- Input conditioning: `rx_serial` passes through a 2-FF synchronizer; both flops reset to 1. All decisions use the synchronized signal `rx_s`.
- States: IDLE, START, DATA, STOP, WAIT_HIGH.
- **IDLE**
  - `rx_s` == 0 → START; clear the bit counter (`clk_cnt` = 0); raise `rx_busy`.
- **START**
  - Count to `CLKS_PER_BIT/2 - 1` (integer division).
  - Sample `rx_s`: 0 → DATA with `clk_cnt` = 0 and `bit_idx` = 0; 1 → glitch, back to IDLE with `rx_busy` low and no pulse.
- **DATA**
  - Every `CLKS_PER_BIT` cycles, sample `rx_s` into `shift[bit_idx]`.
  - After `bit_idx` == 7 is sampled → STOP.
- **STOP**
  - After `CLKS_PER_BIT` cycles, sample `rx_s`.
  - 1 → load `rx_data` from `shift`, pulse `rx_data_ready`, go to IDLE.
  - 0 → pulse `rx_frame_error`, leave `rx_data` unchanged, go to WAIT_HIGH.
- **WAIT_HIGH**
  - Stay until `rx_s` == 1, then go to IDLE.
  - This prevents a held-low break from producing repeated frames or errors.
- `rx_busy` is high in START, DATA, STOP and WAIT_HIGH.
- `clk_cnt` is wide enough for `CLKS_PER_BIT - 1` (`$clog2`). It resets to 0 on every sample point; it never wraps freely.
- `rx_data_ready` and `rx_frame_error` are never high in the same cycle.

## Timing
- Reset values: `rx_data` = 8'h00, `rx_data_ready` = 0, `rx_frame_error` = 0, `rx_busy` = 0, state = IDLE, sync flops = 1.
- Reset takes effect at the next rising edge from any state and aborts a frame in progress. No pulse is emitted for the aborted frame.
- Detection delay: the falling edge on the pin reaches IDLE 2 cycles later, through the synchronizer.
- Sampling: bit n (0..7) is sampled `CLKS_PER_BIT/2 + (n+1)*CLKS_PER_BIT` cycles after START is entered, i.e. mid-bit.
- Output: `rx_data_ready` (or `rx_frame_error`) is registered and asserts the cycle after the stop-bit sample. Total delay from the pin falling edge is about 9.5 bit times + 3 cycles.
- Back-to-back frames: after a good stop sample the block is in IDLE, so a start edge arriving half a bit later is caught. Full line rate is sustained with zero idle gap.
- Consumer contract: the strobe is exactly one cycle. `rx_data` is held until the next good byte, so the downstream stage may sample it any time before then.

## Structure
- Shared package `uart_pkg`:
  - state encoding (IDLE..WAIT_HIGH);
  - default `CLKS_PER_BIT` constant;
  - frame constants `DATA_BITS` = 8, `STOP_BITS` = 1.
- Sub-module `sync_2ff` (parameterised reset value). It is reused for other asynchronous inputs on the board.
- The core is one FSM plus counters and a shift register; no further hierarchy.

## Test plan
All scenarios use `CLKS_PER_BIT` = 16.
- **Single byte:** drive 8'h46 with a good stop bit → exactly one `rx_data_ready` pulse with `rx_data` = 8'h46; `rx_busy` low afterwards; `rx_frame_error` never high.
- **Back-to-back:** drive 8'h46, 8'h01, 8'h10 with no idle gap → three one-cycle pulses, `rx_data` 8'h46, 8'h01, 8'h10 in order, pulses 160 cycles apart.
- **Glitch:** hold `rx_serial` low for 3 cycles, then high → no pulse of either kind; `rx_busy` returns to 0 by cycle 8 of START.
- **Framing error:** send 8'hAA with stop bit = 0 after a prior good 8'h46 → one `rx_frame_error` pulse, no `rx_data_ready`, `rx_data` stays 8'h46.
- **Break:** hold `rx_serial` low for 40 bit times → exactly one `rx_frame_error` pulse; then release high and send 8'h47 → `rx_data` = 8'h47, one ready pulse.
- **Reset mid-frame:** assert `reset` for 1 cycle during bit 4 of 8'hFF → all outputs at reset values next cycle; the remainder of that frame produces no good byte; the next full frame 8'h48 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path: receiver state encoding,
// the default bit period for a 12 MHz clock at 115200 baud, and the 8N1
// frame shape constants.
// No ports (package).
// ---------------------------------------------------------------------------
package uart_pkg;

   // Receiver FSM states, in the order a frame walks through them.
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
   } uart_state_e;

   // 12 MHz / 115200 baud, rounded to the nearest whole clock.
   localparam int DEFAULT_CLKS_PER_BIT = 104;

   // 8N1 framing.
   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;

endpackage : uart_pkg

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for bringing a single asynchronous signal into the
// clk domain. The reset value is a parameter so that idle-high lines (UART)
// and idle-low lines can both start out in their inactive level.
//
// Ports:
//   clk     - destination clock
//   reset   - synchronous, active-high; loads RESET_VALUE into both flops
//   i_async - asynchronous input
//   o_sync  - synchronized output, two clk cycles behind i_async
// ---------------------------------------------------------------------------
module sync_2ff #(
   parameter logic RESET_VALUE = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic i_async,
   output logic o_sync
);

   logic r_meta;
   logic r_sync;

   // First flop may go metastable; the second gives it a full cycle to
   // settle before anything downstream looks at it. Both flops come out of
   // reset at the line's idle level so no false edge is seen after reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_meta <= RESET_VALUE;
         r_sync <= RESET_VALUE;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
      end
   end

   assign o_sync = r_sync;

endmodule : sync_2ff

// File: rtl/uart_byte_receiver.sv
// ---------------------------------------------------------------------------
// uart_byte_receiver
// Recovers 8N1 frames from the asynchronous UART line and presents each
// correctly framed byte with a one-cycle strobe. Frames with a bad stop bit
// raise a one-cycle error pulse instead and never reach rx_data.
//
// Ports:
//   clk            - system clock, rising edge
//   reset          - synchronous, active-high; aborts any frame in progress
//   rx_serial      - asynchronous UART line, idle high
//   rx_data        - last good byte, LSB received first; held until the next
//   rx_data_ready  - one-cycle pulse, same cycle rx_data updates
//   rx_frame_error - one-cycle pulse when the stop bit is sampled low
//   rx_busy        - high from start-bit detection until the frame ends
// ---------------------------------------------------------------------------
module uart_byte_receiver #(
   parameter int CLKS_PER_BIT = uart_pkg::DEFAULT_CLKS_PER_BIT
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           rx_serial,
   output logic [uart_pkg::DATA_BITS-1:0] rx_data,
   output logic                           rx_data_ready,
   output logic                           rx_frame_error,
   output logic                           rx_busy
);

   import uart_pkg::*;

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(DATA_BITS);

   // Start bit is checked at its middle; every later sample is one full
   // bit period on from the previous one, so all samples land mid-bit.
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

   logic                  w_rxS;
   uart_state_e           r_state;
   logic [CNT_W-1:0]      r_clkCnt;
   logic [IDX_W-1:0]      r_bitIdx;
   logic [DATA_BITS-1:0]  r_shift;
   logic [DATA_BITS-1:0]  r_rxData;
   logic                  r_dataReady;
   logic                  r_frameError;
   logic                  r_busy;

   // The raw pin is asynchronous; every decision below uses the
   // synchronized copy. Reset value 1 matches the idle line.
   sync_2ff #(
      .RESET_VALUE (1'b1)
   ) u_rxSync (
      .clk     (clk),
      .reset   (reset),
      .i_async (rx_serial),
      .o_sync  (w_rxS)
   );

   // Receive FSM with its bit-period counter, bit index and shift register.
   // All outputs are registered here so the strobes are clean one-cycle
   // pulses. The counter is cleared at every sample point rather than left
   // to wrap, so each bit period is measured from the previous sample.
   // After a bad stop bit we park in WAIT_HIGH until the line returns high;
   // otherwise a held-low break would be read as an endless run of frames.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_clkCnt     <= '0;
         r_bitIdx     <= '0;
         r_shift      <= '0;
         r_rxData     <= '0;
         r_dataReady  <= 1'b0;
         r_frameError <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_dataReady  <= 1'b0;
         r_frameError <= 1'b0;

         case (r_state)
            IDLE: begin
               r_clkCnt <= '0;
               r_bitIdx <= '0;
               if (!w_rxS) begin
                  r_state <= START;
                  r_busy  <= 1'b1;
               end else begin
                  r_busy  <= 1'b0;
               end
            end

            START: begin
               if (r_clkCnt == HALF_LAST) begin
                  r_clkCnt <= '0;
                  r_bitIdx <= '0;
                  if (!w_rxS) begin
                     r_state <= DATA;
                  end else begin
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end
               end else begin
                  r_clkCnt <= r_clkCnt + CNT_W'(1);
               end
            end

            DATA: begin
               if (r_clkCnt == BIT_LAST) begin
                  r_clkCnt          <= '0;
                  r_shift[r_bitIdx] <= w_rxS;
                  if (r_bitIdx == IDX_LAST) begin
                     r_state <= STOP;
                  end else begin
                     r_bitIdx <= r_bitIdx + IDX_W'(1);
                  end
               end else begin
                  r_clkCnt <= r_clkCnt + CNT_W'(1);
               end
            end

            STOP: begin
               if (r_clkCnt == BIT_LAST) begin
                  r_clkCnt <= '0;
                  if (w_rxS) begin
                     r_rxData    <= r_shift;
                     r_dataReady <= 1'b1;
                     r_state     <= IDLE;
                     r_busy      <= 1'b0;
                  end else begin
                     r_frameError <= 1'b1;
                     r_state      <= WAIT_HIGH;
                  end
               end else begin
                  r_clkCnt <= r_clkCnt + CNT_W'(1);
               end
            end

            WAIT_HIGH: begin
               r_clkCnt <= '0;
               if (w_rxS) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            end

            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign rx_data        = r_rxData;
   assign rx_data_ready  = r_dataReady;
   assign rx_frame_error = r_frameError;
   assign rx_busy        = r_busy;

endmodule : uart_byte_receiver

// File: tb/tb_uart_byte_receiver.sv
// ---------------------------------------------------------------------------
// tb_uart_byte_receiver
// Directed bench for uart_byte_receiver at 16 clocks per bit. Drives whole
// frames on the serial pin and checks the receiver's strobes and data.
// ---------------------------------------------------------------------------
module tb_uart_byte_receiver;

   localparam int CPB = 16;

   logic       clk;
   logic       reset;
   logic       rx_serial;
   logic [7:0] rx_data;
   logic       rx_data_ready;
   logic       rx_frame_error;
   logic       rx_busy;

   int checks   = 0;
   int failures = 0;

   int         cycle        = 0;
   int         readyCount   = 0;
   int         errCount     = 0;
   int         overlapCount = 0;
   logic [7:0] readyData[$];
   int         readyCycles[$];

   int baseReady;
   int baseErr;

   uart_byte_receiver #(
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .rx_serial      (rx_serial),
      .rx_data        (rx_data),
      .rx_data_ready  (rx_data_ready),
      .rx_frame_error (rx_frame_error),
      .rx_busy        (rx_busy)
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Passive monitor on the falling edge: tallies every cycle each strobe is
   // high, so a stretched pulse shows up as an extra count, and logs the
   // byte and cycle number of every ready strobe.
   always @(negedge clk) begin
      cycle = cycle + 1;
      if (rx_data_ready) begin
         readyCount = readyCount + 1;
         readyData.push_back(rx_data);
         readyCycles.push_back(cycle);
      end
      if (rx_frame_error) errCount = errCount + 1;
      if (rx_data_ready && rx_frame_error) overlapCount = overlapCount + 1;
   end

   // One comparison: counts it, and on mismatch counts a failure and reports.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks = checks + 1;
      assert (observed === expected)
      else begin
         failures = failures + 1;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Drive one full frame on the pin: start bit, 8 data bits LSB first,
   // then the given stop bit. Called from a falling edge; returns on one.
   task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
      rx_serial = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_serial = data[i];
         repeat (CPB) @(negedge clk);
      end
      rx_serial = stopBit;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic idleLine(input int cycles);
      rx_serial = 1'b1;
      repeat (cycles) @(negedge clk);
   endtask

   initial begin
      reset     = 1'b1;
      rx_serial = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Reset state.
      checkOutput("reset_rx_data", {24'd0, rx_data}, 32'h00);
      checkOutput("reset_ready", {31'd0, rx_data_ready}, 32'd0);
      checkOutput("reset_error", {31'd0, rx_frame_error}, 32'd0);
      checkOutput("reset_busy", {31'd0, rx_busy}, 32'd0);
      idleLine(2 * CPB);

      // Single byte 0x46.
      $display("[TB] single byte");
      baseReady = readyCount;
      baseErr   = errCount;
      applyStimulus(8'h46, 1'b1);
      idleLine(2 * CPB);
      checkOutput("single_ready_count", readyCount - baseReady, 32'd1);
      checkOutput("single_logged_data", {24'd0, readyData[baseReady]}, 32'h46);
      checkOutput("single_rx_data", {24'd0, rx_data}, 32'h46);
      checkOutput("single_busy_after", {31'd0, rx_busy}, 32'd0);
      checkOutput("single_error_count", errCount - baseErr, 32'd0);

      // Back-to-back 0x46, 0x01, 0x10 with no idle gap.
      $display("[TB] back-to-back");
      baseReady = readyCount;
      baseErr   = errCount;
      applyStimulus(8'h46, 1'b1);
      applyStimulus(8'h01, 1'b1);
      applyStimulus(8'h10, 1'b1);
      idleLine(2 * CPB);
      checkOutput("b2b_ready_count", readyCount - baseReady, 32'd3);
      if (readyCount - baseReady >= 3) begin
         checkOutput("b2b_data0", {24'd0, readyData[baseReady]}, 32'h46);
         checkOutput("b2b_data1", {24'd0, readyData[baseReady + 1]}, 32'h01);
         checkOutput("b2b_data2", {24'd0, readyData[baseReady + 2]}, 32'h10);
         checkOutput("b2b_gap01", readyCycles[baseReady + 1] - readyCycles[baseReady], 32'd160);
         checkOutput("b2b_gap12", readyCycles[baseReady + 2] - readyCycles[baseReady + 1], 32'd160);
      end
      checkOutput("b2b_error_count", errCount - baseErr, 32'd0);

      // Glitch: low for 3 cycles only. Start is detected 3 edges after the
      // fall; the half-bit check 8 cycles into START sends it back to IDLE.
      $display("[TB] glitch");
      baseReady = readyCount;
      baseErr   = errCount;
      rx_serial = 1'b0;
      repeat (3) @(negedge clk);
      rx_serial = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("glitch_busy_during", {31'd0, rx_busy}, 32'd1);
      repeat (8) @(negedge clk);
      checkOutput("glitch_busy_after", {31'd0, rx_busy}, 32'd0);
      idleLine(2 * CPB);
      checkOutput("glitch_ready_count", readyCount - baseReady, 32'd0);
      checkOutput("glitch_error_count", errCount - baseErr, 32'd0);

      // Framing error: good 0x46, then 0xAA with a low stop bit.
      $display("[TB] framing error");
      baseReady = readyCount;
      baseErr   = errCount;
      applyStimulus(8'h46, 1'b1);
      applyStimulus(8'hAA, 1'b0);
      idleLine(2 * CPB);
      checkOutput("ferr_ready_count", readyCount - baseReady, 32'd1);
      checkOutput("ferr_error_count", errCount - baseErr, 32'd1);
      checkOutput("ferr_rx_data_held", {24'd0, rx_data}, 32'h46);
      checkOutput("ferr_busy_after", {31'd0, rx_busy}, 32'd0);

      // Break: line low for 40 bit times, then a normal 0x47.
      $display("[TB] break");
      baseReady = readyCount;
      baseErr   = errCount;
      rx_serial = 1'b0;
      repeat (40 * CPB) @(negedge clk);
      checkOutput("break_busy_held", {31'd0, rx_busy}, 32'd1);
      idleLine(2 * CPB);
      checkOutput("break_error_count", errCount - baseErr, 32'd1);
      checkOutput("break_busy_released", {31'd0, rx_busy}, 32'd0);
      applyStimulus(8'h47, 1'b1);
      idleLine(2 * CPB);
      checkOutput("break_ready_count", readyCount - baseReady, 32'd1);
      checkOutput("break_rx_data", {24'd0, rx_data}, 32'h47);
      checkOutput("break_error_total", errCount - baseErr, 32'd1);

      // Reset for one cycle during bit 4 of 0xFF, then a full 0x48.
      $display("[TB] reset mid-frame");
      baseReady = readyCount;
      baseErr   = errCount;
      rx_serial = 1'b0;
      repeat (CPB) @(negedge clk);
      rx_serial = 1'b1;
      repeat (4 * CPB + CPB / 2) @(negedge clk);
      checkOutput("rst_busy_before", {31'd0, rx_busy}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkOutput("rst_rx_data", {24'd0, rx_data}, 32'h00);
      checkOutput("rst_ready", {31'd0, rx_data_ready}, 32'd0);
      checkOutput("rst_error", {31'd0, rx_frame_error}, 32'd0);
      checkOutput("rst_busy", {31'd0, rx_busy}, 32'd0);
      repeat (4 * CPB) @(negedge clk);
      checkOutput("rst_aborted_ready", readyCount - baseReady, 32'd0);
      applyStimulus(8'h48, 1'b1);
      idleLine(2 * CPB);
      checkOutput("rst_next_ready", readyCount - baseReady, 32'd1);
      checkOutput("rst_next_rx_data", {24'd0, rx_data}, 32'h48);
      checkOutput("rst_error_count", errCount - baseErr, 32'd0);

      // Strobes must never coincide anywhere in the run.
      checkOutput("strobe_overlap", overlapCount, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_uart_byte_receiver
